// File: rtl/armleocpu_cache_arbiter.sv
// Two-requester arbiter for one armleocpu cache port: fetch (r0) and data (r1).
// Grant is held for a whole transaction; losers see WAIT and are counted as stall cycles.
module armleocpu_cache_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        c_reset_done,
  input  logic [3:0]  c_response,
  input  logic [31:0] c_load_data,
  output logic [3:0]  c_cmd,
  output logic [31:0] c_address,
  output logic [31:0] c_store_data,
  output logic [2:0]  c_load_type,
  output logic [1:0]  c_store_type,

  input  logic [3:0]  r0_cmd,
  input  logic [31:0] r0_address,
  input  logic [31:0] r0_store_data,
  input  logic [2:0]  r0_load_type,
  input  logic [1:0]  r0_store_type,
  output logic [3:0]  r0_response,
  output logic [31:0] r0_load_data,
  output logic        r0_reset_done,

  input  logic [3:0]  r1_cmd,
  input  logic [31:0] r1_address,
  input  logic [31:0] r1_store_data,
  input  logic [2:0]  r1_load_type,
  input  logic [1:0]  r1_store_type,
  output logic [3:0]  r1_response,
  output logic [31:0] r1_load_data,
  output logic        r1_reset_done,

  output logic [1:0]  arb_owner,
  input  logic        arb_stall_clear,
  output logic [15:0] arb_stall_count
);

  localparam logic [3:0] CMD_NONE         = 4'd0;
  localparam logic [3:0] RESP_IDLE        = 4'd0;
  localparam logic [3:0] RESP_WAIT        = 4'd1;
  localparam logic [3:0] RESP_DONE        = 4'd2;
  localparam logic [3:0] RESP_ACCESSFAULT = 4'd3;
  localparam logic [3:0] RESP_MISSALIGNED = 4'd4;
  localparam logic [3:0] RESP_PAGEFAULT   = 4'd5;

  // Encoding doubles as the arb_owner debug output.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY_R0 = 2'b01,
    ST_BUSY_R1 = 2'b10
  } state_t;

  // Handshake: a requester raises rN_cmd and holds it (with its fields) until it
  // sees a terminal rN_response; WAIT/IDLE mean not yet accepted or completed.

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;  // 0 = r0, 1 = r1
  logic [15:0] stall_count_q, stall_count_d;

  logic active, busy, terminal, arb_run;
  logic req0, req1;
  logic own0, own1;
  logic win_valid, win_sel, win0, win1;
  logic fwd_valid, fwd_sel;
  logic stall;

  always_comb begin
    active   = rst_n & c_reset_done;
    busy     = (state_q != ST_IDLE);
    terminal = (c_response == RESP_DONE) || (c_response == RESP_ACCESSFAULT) ||
               (c_response == RESP_MISSALIGNED) || (c_response == RESP_PAGEFAULT);
    req0     = (r0_cmd != CMD_NONE);
    req1     = (r1_cmd != CMD_NONE);
    own0     = active && (state_q == ST_BUSY_R0);
    own1     = active && (state_q == ST_BUSY_R1);
    arb_run  = active && (!busy || terminal);

    win_valid = arb_run && (req0 || req1);
    if (req0 && req1) begin
      win_sel = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
    end else begin
      win_sel = req1;
    end
    win0 = win_valid && !win_sel;
    win1 = win_valid && win_sel;

    // An in-flight transaction keeps the port until it terminates or is dropped.
    fwd_valid = 1'b0;
    fwd_sel   = 1'b0;
    if (active && busy && !terminal) begin
      fwd_valid = 1'b1;
      fwd_sel   = (state_q == ST_BUSY_R1);
    end else if (win_valid) begin
      fwd_valid = 1'b1;
      fwd_sel   = win_sel;
    end
  end

  always_comb begin
    c_cmd        = CMD_NONE;
    c_address    = 32'd0;
    c_store_data = 32'd0;
    c_load_type  = 3'd0;
    c_store_type = 2'd0;
    if (fwd_valid) begin
      if (fwd_sel) begin
        c_cmd        = r1_cmd;
        c_address    = r1_address;
        c_store_data = r1_store_data;
        c_load_type  = r1_load_type;
        c_store_type = r1_store_type;
      end else begin
        c_cmd        = r0_cmd;
        c_address    = r0_address;
        c_store_data = r0_store_data;
        c_load_type  = r0_load_type;
        c_store_type = r0_store_type;
      end
    end
  end

  // A fresh grant from IDLE sees the live cache response; a grant taken over on
  // another requester's terminal cycle must not see that foreign response.
  always_comb begin
    r0_response = RESP_IDLE;
    r1_response = RESP_IDLE;
    if (active) begin
      if (own0 || (win0 && !busy)) r0_response = c_response;
      else if (req0)               r0_response = RESP_WAIT;
      if (own1 || (win1 && !busy)) r1_response = c_response;
      else if (req1)               r1_response = RESP_WAIT;
    end
  end

  assign r0_load_data  = c_load_data;
  assign r1_load_data  = c_load_data;
  assign r0_reset_done = c_reset_done;
  assign r1_reset_done = c_reset_done;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (!c_reset_done) begin
      state_d = ST_IDLE;
    end else if (arb_run) begin
      if (win_valid) begin
        state_d      = win_sel ? ST_BUSY_R1 : ST_BUSY_R0;
        last_grant_d = win_sel;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (busy && (c_response == RESP_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    stall = (req0 && !own0 && !win0) || (req1 && !own1 && !win1);
    stall_count_d = stall_count_q;
    if (arb_stall_clear) begin
      stall_count_d = 16'd0;
    end else if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign arb_owner       = state_q;
  assign arb_stall_count = stall_count_q;

endmodule

// File: tb/tb_armleocpu_cache_arbiter.sv
// Bench for armleocpu_cache_arbiter: round-robin and fixed-priority instances share
// the stimulus and are each compared every cycle against an integer-level model.
module tb_armleocpu_cache_arbiter;

  localparam logic [3:0] C_NONE = 4'd0, C_EXEC = 4'd1, C_LOAD = 4'd2, C_STORE = 4'd3, C_FLUSH = 4'd4;
  localparam logic [3:0] R_IDLE = 4'd0, R_WAIT = 4'd1, R_DONE = 4'd2, R_AF = 4'd3, R_MA = 4'd4, R_PF = 4'd5;

  // ---------------- clock / reset / stimulus signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        c_reset_done;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic        stall_clear;
  logic [3:0]  rq_cmd [2];
  logic [31:0] rq_addr [2];
  logic [31:0] rq_sd [2];
  logic [2:0]  rq_lt [2];
  logic [1:0]  rq_st [2];

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic [3:0]  o_c_cmd [2];
  logic [31:0] o_c_addr [2];
  logic [31:0] o_c_sd [2];
  logic [2:0]  o_c_lt [2];
  logic [1:0]  o_c_st [2];
  logic [3:0]  o_r0_resp [2];
  logic [3:0]  o_r1_resp [2];
  logic [31:0] o_r0_ld [2];
  logic [31:0] o_r1_ld [2];
  logic        o_r0_rd [2];
  logic        o_r1_rd [2];
  logic [1:0]  o_owner [2];
  logic [15:0] o_cnt [2];

  armleocpu_cache_arbiter #(.FIXED_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .c_reset_done(c_reset_done), .c_response(c_response), .c_load_data(c_load_data),
    .c_cmd(o_c_cmd[0]), .c_address(o_c_addr[0]), .c_store_data(o_c_sd[0]),
    .c_load_type(o_c_lt[0]), .c_store_type(o_c_st[0]),
    .r0_cmd(rq_cmd[0]), .r0_address(rq_addr[0]), .r0_store_data(rq_sd[0]),
    .r0_load_type(rq_lt[0]), .r0_store_type(rq_st[0]),
    .r0_response(o_r0_resp[0]), .r0_load_data(o_r0_ld[0]), .r0_reset_done(o_r0_rd[0]),
    .r1_cmd(rq_cmd[1]), .r1_address(rq_addr[1]), .r1_store_data(rq_sd[1]),
    .r1_load_type(rq_lt[1]), .r1_store_type(rq_st[1]),
    .r1_response(o_r1_resp[0]), .r1_load_data(o_r1_ld[0]), .r1_reset_done(o_r1_rd[0]),
    .arb_owner(o_owner[0]), .arb_stall_clear(stall_clear), .arb_stall_count(o_cnt[0])
  );

  armleocpu_cache_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .c_reset_done(c_reset_done), .c_response(c_response), .c_load_data(c_load_data),
    .c_cmd(o_c_cmd[1]), .c_address(o_c_addr[1]), .c_store_data(o_c_sd[1]),
    .c_load_type(o_c_lt[1]), .c_store_type(o_c_st[1]),
    .r0_cmd(rq_cmd[0]), .r0_address(rq_addr[0]), .r0_store_data(rq_sd[0]),
    .r0_load_type(rq_lt[0]), .r0_store_type(rq_st[0]),
    .r0_response(o_r0_resp[1]), .r0_load_data(o_r0_ld[1]), .r0_reset_done(o_r0_rd[1]),
    .r1_cmd(rq_cmd[1]), .r1_address(rq_addr[1]), .r1_store_data(rq_sd[1]),
    .r1_load_type(rq_lt[1]), .r1_store_type(rq_st[1]),
    .r1_response(o_r1_resp[1]), .r1_load_data(o_r1_ld[1]), .r1_reset_done(o_r1_rd[1]),
    .arb_owner(o_owner[1]), .arb_stall_clear(stall_clear), .arb_stall_count(o_cnt[1])
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model state per instance: owner -1 none / 0 / 1, last grant, stall counter.
  int m_owner [2];
  int m_last [2];
  int m_cnt [2];
  int nx_owner [2];
  int nx_last [2];
  int nx_cnt [2];

  task automatic model_check(input int d);
    bit act, term, arb, stall;
    int owner, win, drv;
    logic [3:0] e_resp [2];
    logic [3:0] got_resp [2];
    if (!rst_n) begin
      m_owner[d] = -1; m_last[d] = 1; m_cnt[d] = 0;
    end
    act   = (rst_n === 1'b1) && (c_reset_done === 1'b1);
    term  = (c_response == R_DONE) || (c_response == R_AF) || (c_response == R_MA) || (c_response == R_PF);
    owner = act ? m_owner[d] : -1;
    arb   = act && (owner < 0 || term);
    win   = -1;
    if (arb) begin
      if (rq_cmd[0] != C_NONE && rq_cmd[1] != C_NONE) win = (d == 1) ? 0 : 1 - m_last[d];
      else if (rq_cmd[0] != C_NONE) win = 0;
      else if (rq_cmd[1] != C_NONE) win = 1;
    end
    drv = -1;
    if (owner >= 0 && !term) drv = owner;
    else if (win >= 0) drv = win;

    check_val($sformatf("d%0d_c_cmd", d),   o_c_cmd[d],  drv >= 0 ? rq_cmd[drv]  : 4'd0);
    check_val($sformatf("d%0d_c_addr", d),  o_c_addr[d], drv >= 0 ? rq_addr[drv] : 32'd0);
    check_val($sformatf("d%0d_c_sd", d),    o_c_sd[d],   drv >= 0 ? rq_sd[drv]   : 32'd0);
    check_val($sformatf("d%0d_c_lt", d),    o_c_lt[d],   drv >= 0 ? rq_lt[drv]   : 3'd0);
    check_val($sformatf("d%0d_c_st", d),    o_c_st[d],   drv >= 0 ? rq_st[drv]   : 2'd0);

    stall = 1'b0;
    got_resp[0] = o_r0_resp[d];
    got_resp[1] = o_r1_resp[d];
    for (int i = 0; i < 2; i++) begin
      if (!act)                       e_resp[i] = R_IDLE;
      else if (i == owner)            e_resp[i] = c_response;
      else if (i == win && owner < 0) e_resp[i] = c_response;
      else if (rq_cmd[i] != C_NONE)   e_resp[i] = R_WAIT;
      else                            e_resp[i] = R_IDLE;
      if (rq_cmd[i] != C_NONE && i != owner && i != win) stall = 1'b1;
      check_val($sformatf("d%0d_r%0d_resp", d, i), got_resp[i], e_resp[i]);
    end

    check_val($sformatf("d%0d_r0_ld", d), o_r0_ld[d], c_load_data);
    check_val($sformatf("d%0d_r1_ld", d), o_r1_ld[d], c_load_data);
    check_val($sformatf("d%0d_r0_rd", d), o_r0_rd[d], c_reset_done);
    check_val($sformatf("d%0d_r1_rd", d), o_r1_rd[d], c_reset_done);
    check_val($sformatf("d%0d_owner", d), o_owner[d], m_owner[d] < 0 ? 2'b00 : (m_owner[d] == 0 ? 2'b01 : 2'b10));
    check_val($sformatf("d%0d_stall_cnt", d), o_cnt[d], m_cnt[d]);

    nx_owner[d] = m_owner[d];
    nx_last[d]  = m_last[d];
    if (!rst_n) begin
      nx_owner[d] = -1; nx_last[d] = 1;
    end else if (!c_reset_done) begin
      nx_owner[d] = -1;
    end else if (arb) begin
      nx_owner[d] = win;
      if (win >= 0) nx_last[d] = win;
    end else if (c_response == R_IDLE) begin
      nx_owner[d] = -1;
    end
    if (!rst_n || stall_clear) nx_cnt[d] = 0;
    else if (stall && m_cnt[d] < 65535) nx_cnt[d] = m_cnt[d] + 1;
    else nx_cnt[d] = m_cnt[d];
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change at posedge+1; outputs are sampled mid-cycle, state advances on posedge.
  task automatic tick();
    #3;
    for (int d = 0; d < 2; d++) model_check(d);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = nx_owner[d]; m_last[d] = nx_last[d]; m_cnt[d] = nx_cnt[d];
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] cmd, input logic [31:0] addr);
    rq_cmd[i]  = cmd;
    rq_addr[i] = addr;
    rq_sd[i]   = (i == 0) ? 32'd0 : $urandom;
    rq_lt[i]   = 3'($urandom_range(0, 7));
    rq_st[i]   = 2'($urandom_range(0, 3));
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    c_response = R_IDLE;
    set_req(0, C_NONE, 32'd0);
    set_req(1, C_NONE, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; c_reset_done = 1'b0; c_response = R_IDLE; c_load_data = 32'd0; stall_clear = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(i, C_NONE, 32'd0);
      m_owner[i] = -1; m_last[i] = 1; m_cnt[i] = 0;
    end
    @(posedge clk); #1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    c_reset_done = 1'b1;
    tick();

    // r0 fetch alone: WAIT, WAIT, DONE with data 0x13
    set_req(0, C_EXEC, 32'h2000);
    c_response = R_WAIT;
    #2;
    check_val("s1_c_cmd", o_c_cmd[0], C_EXEC);
    check_val("s1_c_addr", o_c_addr[0], 32'h2000);
    check_val("s1_r0_wait0", o_r0_resp[0], R_WAIT);
    tick();
    #2;
    check_val("s1_owner_busy", o_owner[0], 2'b01);
    check_val("s1_r1_idle", o_r1_resp[0], R_IDLE);
    tick();
    c_response = R_DONE; c_load_data = 32'h13;
    #2;
    check_val("s1_r0_done", o_r0_resp[0], R_DONE);
    check_val("s1_r0_data", o_r0_ld[0], 32'h13);
    tick();
    set_req(0, C_NONE, 32'd0); c_response = R_IDLE;
    tick();
    tick();

    // simultaneous requests after reset; r0 keeps its command through DONE
    reset_pulse();
    set_req(0, C_LOAD, 32'h100);
    set_req(1, C_STORE, 32'h200);
    c_response = R_WAIT;
    tick();
    repeat (2) begin
      #2;
      check_val("s2_r1_wait", o_r1_resp[0], R_WAIT);
      tick();
    end
    c_response = R_DONE;
    #2;
    check_val("s2_cnt3", o_cnt[0], 16'd3);
    check_val("s2_rr_switch_cmd", o_c_cmd[0], C_STORE);
    check_val("s2_rr_switch_addr", o_c_addr[0], 32'h200);
    check_val("s2_fp_keep_cmd", o_c_cmd[1], C_LOAD);
    tick();
    c_response = R_WAIT;
    #2;
    check_val("s2_rr_owner_r1", o_owner[0], 2'b10);
    check_val("s2_rr_r0_wait", o_r0_resp[0], R_WAIT);
    check_val("s2_fp_owner_r0", o_owner[1], 2'b01);
    check_val("s2_fp_r1_wait", o_r1_resp[1], R_WAIT);
    tick();
    set_req(0, C_NONE, 32'd0); set_req(1, C_NONE, 32'd0); c_response = R_IDLE;
    repeat (2) tick();

    // r1 load page-faults
    reset_pulse();
    set_req(1, C_LOAD, 32'h300);
    c_response = R_WAIT;
    repeat (2) tick();
    c_response = R_PF;
    #2;
    check_val("s3_r1_pf", o_r1_resp[0], R_PF);
    check_val("s3_r0_idle", o_r0_resp[0], R_IDLE);
    tick();
    set_req(1, C_NONE, 32'd0); c_response = R_IDLE;
    #2;
    check_val("s3_r1_after_pf", o_r1_resp[0], R_IDLE);
    tick();

    // cache not ready, then async reset in the middle of a WAIT
    set_req(0, C_EXEC, 32'h400); set_req(1, C_LOAD, 32'h500);
    c_reset_done = 1'b0;
    #2;
    check_val("s4_nrd_cmd", o_c_cmd[0], C_NONE);
    check_val("s4_nrd_r0", o_r0_resp[0], R_IDLE);
    check_val("s4_nrd_r1", o_r1_resp[0], R_IDLE);
    tick();
    #2;
    check_val("s4_nrd_owner", o_owner[0], 2'b00);
    c_reset_done = 1'b1; c_response = R_WAIT;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check_val("s4_rst_owner", o_owner[0], 2'b00);
    check_val("s4_rst_cnt", o_cnt[0], 16'd0);
    check_val("s4_rst_cmd", o_c_cmd[0], C_NONE);
    tick();
    rst_n = 1'b1; set_req(0, C_NONE, 32'd0); set_req(1, C_NONE, 32'd0); c_response = R_IDLE;
    tick();

    // stall counter saturation, then clear against a stall
    stall_clear = 1'b1;
    tick();
    stall_clear = 1'b0;
    set_req(0, C_LOAD, 32'h600); set_req(1, C_STORE, 32'h700);
    c_response = R_WAIT;
    repeat (65534) tick();
    #2;
    check_val("s5_cnt_fffe", o_cnt[0], 16'hFFFE);
    tick();
    repeat (2) tick();
    #2;
    check_val("s5_cnt_sat", o_cnt[0], 16'hFFFF);
    check_val("s5_cnt_sat_fp", o_cnt[1], 16'hFFFF);
    stall_clear = 1'b1;
    tick();
    stall_clear = 1'b0;
    #2;
    check_val("s5_cnt_clr", o_cnt[0], 16'd0);
    tick();

    // randomized traffic
    reset_pulse();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (rq_cmd[i] == C_NONE) begin
          if ($urandom_range(0, 99) < 40)
            set_req(i, 4'($urandom_range(int'(C_EXEC), int'(C_FLUSH))), $urandom);
        end else if ($urandom_range(0, 99) < 10) begin
          set_req(i, C_NONE, 32'd0);
        end
      end
      case ($urandom_range(0, 19))
        0, 1, 2:                  c_response = R_IDLE;
        3, 4, 5, 6, 7, 8, 9, 10:  c_response = R_WAIT;
        11, 12, 13, 14, 15:       c_response = R_DONE;
        16:                       c_response = R_AF;
        17:                       c_response = R_MA;
        default:                  c_response = R_PF;
      endcase
      c_load_data  = $urandom;
      c_reset_done = ($urandom_range(0, 99) >= 3);
      stall_clear  = ($urandom_range(0, 99) < 2);
      rst_n        = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
